// File: rtl/eth_phy_mgmt_multi.sv
// Multi-port PHY management: staggered PHY resets, readiness tracking and
// round-robin arbitration of per-port register accesses onto one MDIO engine.
module eth_phy_mgmt_multi #(
  parameter int       NUM_PORTS     = 2,
  parameter bit [4:0] PHY_ADDR_BASE = 5'd1,
  parameter int       RST_HOLD_CYC  = 500000,
  parameter int       RST_GAP_CYC   = 50000,
  parameter int       POST_RST_CYC  = 5000,
  parameter int       TIMEOUT_CYC   = 65535
) (
  input  logic                    clk_50m,
  input  logic                    sys_rst_n,
  output logic [NUM_PORTS-1:0]    net_rst_n,
  output logic [NUM_PORTS-1:0]    phy_ready,
  input  logic [NUM_PORTS-1:0]    port_req,
  input  logic [NUM_PORTS-1:0]    port_wr,
  input  logic [5*NUM_PORTS-1:0]  port_reg_addr,
  input  logic [16*NUM_PORTS-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]    port_ack,
  output logic                    port_err,
  output logic [15:0]             port_rdata,
  output logic                    mdio_start,
  output logic                    mdio_wr,
  output logic [4:0]              mdio_phy_addr,
  output logic [4:0]              mdio_reg_addr,
  output logic [15:0]             mdio_wdata,
  input  logic                    mdio_done,
  input  logic [15:0]             mdio_rdata
);

  localparam int FINAL = RST_HOLD_CYC + (NUM_PORTS-1)*RST_GAP_CYC
                       + POST_RST_CYC;
  localparam int CW = $clog2(FINAL) + 1;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_ACK
  } state_t;

  state_t                 r_state, w_next;
  logic [CW-1:0]          r_cnt;
  logic [NUM_PORTS-1:0]   r_net, r_rdy;
  logic [PW-1:0]          r_ptr, r_gnt, w_gnt;
  logic [PW:0]            w_j;
  logic                   w_found;
  logic [NUM_PORTS-1:0]   w_elig;
  logic [TW-1:0]          r_tcnt;
  logic                   w_tmo;
  logic                   r_err;
  logic [15:0]            r_rdata;
  logic                   r_wr;
  logic [4:0]             r_phy, r_reg;
  logic [15:0]            r_wd;
  logic [NUM_PORTS-1:0]   w_ack;

  // Reset sequencer: one counter, each port releases at its own threshold
  always_ff @(posedge clk_50m) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
      r_net <= '0;
      r_rdy <= '0;
    end else begin
      if (r_cnt != CW'(FINAL)) r_cnt <= r_cnt + 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (r_cnt == CW'(RST_HOLD_CYC + i*RST_GAP_CYC))
          r_net[i] <= 1'b1;
        if (r_cnt == CW'(RST_HOLD_CYC + i*RST_GAP_CYC + POST_RST_CYC))
          r_rdy[i] <= 1'b1;
      end
    end
  end

  assign w_elig = port_req & r_rdy;
  assign w_tmo  = (r_tcnt == TW'(TIMEOUT_CYC - 1));

  // Round-robin search upward from the pointer, wrapping at NUM_PORTS
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_j     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_j = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_j >= (PW+1)'(NUM_PORTS)) w_j = w_j - (PW+1)'(NUM_PORTS);
      if (!w_found && w_elig[w_j[PW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_j[PW-1:0];
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk_50m) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Arbiter next-state and strobe outputs
  always_comb begin
    w_next = r_state;
    w_ack  = '0;
    unique case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mdio_done || w_tmo) w_next = S_ACK;
      S_ACK: begin
        w_next = S_IDLE;
        w_ack  = NUM_PORTS'(1) << r_gnt;
      end
    endcase
  end

  // Command latch, timeout counter and completion capture
  always_ff @(posedge clk_50m) begin
    if (!sys_rst_n) begin
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_wr    <= 1'b0;
      r_phy   <= '0;
      r_reg   <= '0;
      r_wd    <= '0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_found) begin
          r_gnt <= w_gnt;
          r_wr  <= port_wr[w_gnt];
          r_reg <= port_reg_addr[5*w_gnt +: 5];
          r_wd  <= port_wdata[16*w_gnt +: 16];
          r_phy <= PHY_ADDR_BASE + 5'(w_gnt);
        end
        S_ISSUE: r_tcnt <= '0;
        S_WAIT: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (mdio_done) begin
            r_rdata <= mdio_rdata;
            r_err   <= 1'b0;
          end else if (w_tmo) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        S_ACK: r_ptr <= (r_gnt == PW'(NUM_PORTS-1)) ? '0 : r_gnt + 1'b1;
      endcase
    end
  end

  assign net_rst_n     = r_net;
  assign phy_ready     = r_rdy;
  assign port_ack      = w_ack;
  assign port_err      = (r_state == S_ACK) & r_err;
  assign port_rdata    = r_rdata;
  assign mdio_start    = (r_state == S_ISSUE);
  assign mdio_wr       = r_wr;
  assign mdio_phy_addr = r_phy;
  assign mdio_reg_addr = r_reg;
  assign mdio_wdata    = r_wd;

endmodule

// File: tb/tb_eth_phy_mgmt_multi.sv
// Bench for eth_phy_mgmt_multi: reset sequencing, RR arbitration,
// timeout completion and mid-transaction reset, scoreboard-checked.
module tb_eth_phy_mgmt_multi;

  localparam int N = 4;

  logic            clk_50m = 1'b0;
  logic            sys_rst_n;
  logic [N-1:0]    net_rst_n, phy_ready, port_ack;
  logic [N-1:0]    port_req, port_wr;
  logic [5*N-1:0]  port_reg_addr;
  logic [16*N-1:0] port_wdata;
  logic            port_err, mdio_start, mdio_wr, mdio_done;
  logic [15:0]     port_rdata, mdio_wdata, mdio_rdata;
  logic [4:0]      mdio_phy_addr, mdio_reg_addr;

  always #10 clk_50m = ~clk_50m;

  eth_phy_mgmt_multi #(
    .NUM_PORTS(N), .PHY_ADDR_BASE(5'd1), .RST_HOLD_CYC(20),
    .RST_GAP_CYC(5), .POST_RST_CYC(3), .TIMEOUT_CYC(16)
  ) dut (
    .clk_50m(clk_50m), .sys_rst_n(sys_rst_n),
    .net_rst_n(net_rst_n), .phy_ready(phy_ready),
    .port_req(port_req), .port_wr(port_wr),
    .port_reg_addr(port_reg_addr), .port_wdata(port_wdata),
    .port_ack(port_ack), .port_err(port_err), .port_rdata(port_rdata),
    .mdio_start(mdio_start), .mdio_wr(mdio_wr),
    .mdio_phy_addr(mdio_phy_addr), .mdio_reg_addr(mdio_reg_addr),
    .mdio_wdata(mdio_wdata), .mdio_done(mdio_done),
    .mdio_rdata(mdio_rdata)
  );

  typedef struct {
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic        wr;
    logic [15:0] wd;
  } cmd_t;

  typedef struct {
    int          port;
    logic        err;
    logic [15:0] rd;
    bit          tmo;
  } ack_t;

  cmd_t cq[$];
  ack_t aq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = -100;
  int   pend[N];
  bit   eng_en;
  int   eng_cnt;
  int   last_start;
  int   first_start;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_vec(int c, int base);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = (c >= base + 5*i);
    return v;
  endfunction

  task automatic step();
    cmd_t c;
    ack_t a;
    @(posedge clk_50m);
    cyc++;
    @(negedge clk_50m);
    mdio_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        mdio_done  = 1'b1;
        mdio_rdata = 16'h1000 + {11'b0, mdio_phy_addr - 5'd1};
      end
    end
    if (mdio_start) begin
      if (first_start < 0) first_start = cyc;
      last_start = cyc;
      if (eng_en) eng_cnt = 4;
      chk("cmd_q", cq.size() > 0, 1);
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("mdio_phy", mdio_phy_addr, c.phy);
        chk("mdio_reg", mdio_reg_addr, c.rg);
        chk("mdio_wr", mdio_wr, c.wr);
        chk("mdio_wd", mdio_wdata, c.wd);
      end
    end
    if (port_ack != '0) begin
      chk("ack_q", aq.size() > 0, 1);
      if (aq.size() > 0) begin
        a = aq.pop_front();
        chk("ack_port", port_ack, 32'(1) << a.port);
        chk("ack_err", port_err, a.err);
        chk("ack_rdata", port_rdata, a.rd);
        if (a.tmo) chk("tmo_lat", cyc - last_start, 17);
      end
      for (int p = 0; p < N; p++)
        if (port_ack[p] && pend[p] > 0) begin
          pend[p]--;
          if (pend[p] == 0) port_req[p] = 1'b0;
        end
    end
  endtask

  task automatic set_req(int p, logic wr, logic [4:0] rg,
                         logic [15:0] wd, int n);
    port_wr[p]             = wr;
    port_reg_addr[5*p +: 5] = rg;
    port_wdata[16*p +: 16]  = wd;
    pend[p]                = n;
    port_req[p]            = 1'b1;
  endtask

  task automatic expect_tx(int p, logic wr, logic [4:0] rg, logic [15:0] wd,
                           logic err, logic [15:0] rd, bit tmo);
    cmd_t c;
    ack_t a;
    c.phy = 5'd1 + 5'(p);
    c.rg  = rg;
    c.wr  = wr;
    c.wd  = wd;
    a.port = p;
    a.err  = err;
    a.rd   = rd;
    a.tmo  = tmo;
    cq.push_back(c);
    aq.push_back(a);
  endtask

  task automatic drain(int budget);
    int k;
    k = 0;
    while ((aq.size() > 0 || cq.size() > 0) && k < budget) begin
      step();
      k++;
    end
    chk("drain", aq.size() + cq.size(), 0);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_net"}, net_rst_n, 0);
    chk({tag, "_rdy"}, phy_ready, 0);
    chk({tag, "_ack"}, port_ack, 0);
    chk({tag, "_err"}, port_err, 0);
    chk({tag, "_rdata"}, port_rdata, 0);
    chk({tag, "_start"}, mdio_start, 0);
    chk({tag, "_wr"}, mdio_wr, 0);
    chk({tag, "_phy"}, mdio_phy_addr, 0);
    chk({tag, "_reg"}, mdio_reg_addr, 0);
    chk({tag, "_wd"}, mdio_wdata, 0);
  endtask

  initial begin
    cmd_t c;
    int   k;
    sys_rst_n     = 1'b0;
    port_req      = '0;
    port_wr       = '0;
    port_reg_addr = '0;
    port_wdata    = '0;
    mdio_done     = 1'b0;
    mdio_rdata    = '0;
    eng_en        = 1'b1;
    eng_cnt       = 0;
    last_start    = 0;
    first_start   = -1;
    for (int p = 0; p < N; p++) pend[p] = 0;

    repeat (3) step();
    chk_reset_outs("rst0");

    sys_rst_n = 1'b1;
    cyc = -1;
    for (int e = 0; e <= 40; e++) begin
      step();
      chk("net_rst_n", net_rst_n, exp_vec(cyc, 20));
      chk("phy_ready", phy_ready, exp_vec(cyc, 23));
      if (cyc == 10) begin
        set_req(3, 1'b0, 5'h01, 16'h0A03, 1);
        expect_tx(3, 1'b0, 5'h01, 16'h0A03, 1'b0, 16'h1003, 1'b0);
      end
    end
    chk("first_start", first_start, 39);
    drain(50);

    for (int p = 0; p < N; p++)
      set_req(p, 1'b0, 5'(p + 2), 16'h0A00 + 16'(p), (p == 0) ? 2 : 1);
    for (int i = 0; i < 5; i++) begin
      k = i % N;
      expect_tx(k, 1'b0, 5'(k + 2), 16'h0A00 + 16'(k), 1'b0,
                16'h1000 + 16'(k), 1'b0);
    end
    drain(100);
    repeat (2) step();
    chk("rdata_hold", port_rdata, 16'h1000);

    set_req(2, 1'b0, 5'h03, 16'h0B02, 1);
    expect_tx(2, 1'b0, 5'h03, 16'h0B02, 1'b0, 16'h1002, 1'b0);
    drain(30);

    set_req(0, 1'b0, 5'h04, 16'h0B00, 1);
    set_req(3, 1'b0, 5'h05, 16'h0B03, 1);
    expect_tx(3, 1'b0, 5'h05, 16'h0B03, 1'b0, 16'h1003, 1'b0);
    expect_tx(0, 1'b0, 5'h04, 16'h0B00, 1'b0, 16'h1000, 1'b0);
    drain(40);

    eng_en = 1'b0;
    set_req(1, 1'b1, 5'h1F, 16'hBEEF, 1);
    expect_tx(1, 1'b1, 5'h1F, 16'hBEEF, 1'b1, 16'h0000, 1'b1);
    drain(60);
    eng_en = 1'b1;

    set_req(2, 1'b0, 5'h02, 16'h0C02, 1);
    expect_tx(2, 1'b0, 5'h02, 16'h0C02, 1'b0, 16'h1002, 1'b0);
    drain(30);

    eng_en = 1'b0;
    set_req(0, 1'b0, 5'h06, 16'h0D00, 1);
    c.phy = 5'd1;
    c.rg  = 5'h06;
    c.wr  = 1'b0;
    c.wd  = 16'h0D00;
    cq.push_back(c);
    k = 0;
    while (cq.size() > 0 && k < 20) begin
      step();
      k++;
    end
    chk("rst_cmd", cq.size(), 0);
    repeat (3) step();
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    port_req  = '0;
    for (int p = 0; p < N; p++) pend[p] = 0;
    chk_reset_outs("rst1");
    cyc = -1;
    for (int e = 0; e <= 25; e++) begin
      step();
      chk("net_rst_n2", net_rst_n, exp_vec(cyc, 20));
    end
    chk("ack_q_end", aq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_phy_mgmt_multi.md
Name: eth_phy_mgmt_multi

Overview:
- Parametrised management controller for NUM_PORTS RGMII PHYs (KSZ9031-class) sharing one MDIO engine.
- Replaces the per-port reset and MDIO wiring in the dual-port UDP loop top. It generates staggered PHY hardware resets, tracks per-port readiness, and round-robin arbitrates register read/write requests from each port's datapath onto one external MDIO master.
- Sits in the clk_50m domain beside the IDELAYCTRL/MMCM logic, one instance per board.

Parameters:
- NUM_PORTS, 2, number of PHY ports (1..8).
- PHY_ADDR_BASE, 5'd1, MDIO PHY address of port 0; port i uses PHY_ADDR_BASE+i (mod 32).
- RST_HOLD_CYC, 500000, cycles all net_rst_n held low after reset release (10 ms at 50 MHz).
- RST_GAP_CYC, 50000, stagger between consecutive port reset releases.
- POST_RST_CYC, 5000, cycles from a port's reset release to its phy_ready.
- TIMEOUT_CYC, 65535, maximum wait for mdio_done before error completion.

Ports:
- clk_50m  in  1  sole clock.
- sys_rst_n  in  1  synchronous, active-low reset.
- net_rst_n  out  NUM_PORTS  per-PHY hardware reset, active low.
- phy_ready  out  NUM_PORTS  port reset sequence complete.
- port_req  in  NUM_PORTS  request; held high until port_ack.
- port_wr  in  NUM_PORTS  1 = write, 0 = read.
- port_reg_addr  in  5*NUM_PORTS  register address, port i at [5i+4:5i].
- port_wdata  in  16*NUM_PORTS  write data, port i at [16i+15:16i].
- port_ack  out  NUM_PORTS  one-cycle completion pulse.
- port_err  out  1  valid with port_ack; 1 = timeout.
- port_rdata  out  16  read data, valid with port_ack, held until next ack.
- mdio_start  out  1  one-cycle command strobe to MDIO engine.
- mdio_wr  out  1  command direction.
- mdio_phy_addr  out  5  target PHY.
- mdio_reg_addr  out  5  target register.
- mdio_wdata  out  16  write data.
- mdio_done  in  1  one-cycle engine completion.
- mdio_rdata  in  16  engine read data, valid with mdio_done.

Behaviour:
- All state is reset synchronously while sys_rst_n=0. Reset values:
  - net_rst_n=0, phy_ready=0, port_ack=0, port_err=0, port_rdata=0.
  - mdio_start=0, mdio_wr=0, mdio_*addr=0, mdio_wdata=0.
  - RR pointer=0, FSM=IDLE, sequencer count=0.
- Reset sequencer:
  - Counter cnt starts at 0 on the first edge with sys_rst_n=1 and increments, saturating once the last phy_ready has asserted.
  - net_rst_n[i] rises on the edge where cnt reaches RST_HOLD_CYC + i*RST_GAP_CYC.
  - phy_ready[i] rises POST_RST_CYC cycles after net_rst_n[i].
  - Both stay high until reset. Counter width: $clog2 of the final value + 1.
- Arbiter FSM (IDLE, ISSUE, WAIT, ACK):
  - IDLE: eligible = port_req & phy_ready. If eligible is nonzero, grant g = first eligible index searching upward from the RR pointer with wrap. Latch g, port_wr[g], port_reg_addr[g], port_wdata[g], and PHY address PHY_ADDR_BASE+g into the mdio_* registers, then go to ISSUE.
  - ISSUE: mdio_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - WAIT: on mdio_done, capture mdio_rdata (writes capture the engine value; don't-care) and set err=0, go to ACK. If the counter reaches TIMEOUT_CYC with no done, set rdata=0, err=1, go to ACK. If done and timeout coincide, done wins.
  - ACK: port_ack[g]=1 and port_err valid for one cycle; port_rdata updates the same cycle; pointer=(g+1) mod NUM_PORTS; return to IDLE. The next grant is possible no earlier than the cycle after ACK, so a request-to-start gap of at least 2 cycles is required.
- Deasserting port_req mid-transaction does not abort; the ack is still issued.
- Requests from a port with phy_ready=0 are never granted and never acked.
- mdio_done outside WAIT is ignored.
- mdio_* address/data outputs hold their values between commands.
- Reset mid-operation aborts any transaction with no ack. All net_rst_n return low and the full sequence restarts from cnt=0.

Test Plan:
- Use NUM_PORTS=4, RST_HOLD_CYC=20, RST_GAP_CYC=5, POST_RST_CYC=3, TIMEOUT_CYC=16, PHY_ADDR_BASE=1.
- Release sys_rst_n at cycle 0 -> net_rst_n bits rise at cycles 20/25/30/35; phy_ready bits rise at 23/28/33/38.
- port_req[3] high at cycle 10 with reg 5'h01 -> no mdio_start before cycle 38; then mdio_start with mdio_phy_addr=4, mdio_reg_addr=1.
- After all ready, hold all four reads; engine returns mdio_done 4 cycles after each start with rdata=16'h1000+port -> acks in order 0,1,2,3,0 with port_rdata 1000,1001,1002,1003, err=0.
- Last grant=2, then port_req[0] and port_req[3] rise together -> port 3 granted first, port 0 next.
- Write 16'hBEEF to reg 5'h1F on port 1 with no mdio_done -> port_ack[1] and port_err=1 17 cycles after mdio_start; port_rdata=0. A following request is granted normally.
- Assert sys_rst_n=0 for 1 cycle during WAIT -> no ack; all outputs return to reset values; net_rst_n[0] rises again 20 cycles after release.
